mem_access_unit: RTL

- Memory-side datapath stage directly downstream of the control unit: owns MAR and MDR and sequences every RAM transaction the control unit requests through its MD_read/Write strobes.
- Presents a registered, fixed-latency handshake to a synchronous word RAM.
- Reports completion back to the control unit via mem_busy and mem_done, so the load/store T-states can hold until data is ready.

---
 rtl/mem_access_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR owner that sequences fixed-latency RAM reads and writes
module mem_access_unit #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              MD_read,
   input  logic              Write,
   input  logic [DATA_W-1:0] bus_in,
   output logic [ADDR_W-1:0] mar_q,
   output logic [DATA_W-1:0] mdr_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              err_overlap
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   mar_d, ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   mdr_d, ram_wdata_q, ram_wdata_d;
   logic                ram_re_q, ram_re_d, ram_we_q, ram_we_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_re      = ram_re_q;
   assign ram_we      = ram_we_q;
   assign mem_busy    = busy_q;
   assign mem_done    = done_q;
   assign err_overlap = err_q;
   // next state: register loads, request acceptance, wait countdown (counter reaches 0 on the cycle before completion), clear
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mar_d       = MARin ? bus_in[ADDR_W-1:0] : mar_q;
      mdr_d       = MDRin ? bus_in : mdr_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_re_d    = 1'b0;
      ram_we_d    = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      if (state_q == IDLE) begin
         if (MD_read && Write) begin
            err_d = 1'b1;
         end else if (MD_read || Write) begin
            ram_addr_d  = mar_q;
            ram_wdata_d = Write ? mdr_q : ram_wdata_q;
            ram_re_d    = MD_read;
            ram_we_d    = Write;
            cnt_d       = MD_read ? 4'(RD_LAT) : 4'(WR_LAT);
            busy_d      = 1'b1;
            state_d     = MD_read ? RD_WAIT : WR_WAIT;
         end
      end else begin
         if (MD_read || Write) err_d = 1'b1;
         if (cnt_q == 4'd0) begin
            mdr_d   = (state_q == RD_WAIT) ? ram_rdata : mdr_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
      if (clear) begin
         state_d     = IDLE;
         cnt_d       = '0;
         mar_d       = '0;
         mdr_d       = '0;
         ram_addr_d  = '0;
         ram_wdata_d = '0;
         ram_re_d    = 1'b0;
         ram_we_d    = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b0;
      end
   end
   // state and output registers, all zeroed by the async reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mar_q       <= '0;
         mdr_q       <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_re_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mar_q       <= mar_d;
         mdr_q       <= mdr_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_re_q    <= ram_re_d;
         ram_we_q    <= ram_we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end
endmodule
